if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage LoongArch pipeline that replaces the single-cycle datapath. It owns the PC, drives the instruction SRAM (synchronous read, one-cycle latency) and hands `{inst, pc}` to the decode stage (ID) through a valid/allowin handshake. It accepts branch/jump redirects from ID and squashes the wrong-path instruction it holds. Instructions are buffered locally while ID stalls.

## Interface
- RESET_PC, 32'h1c00_0000, address of the first instruction fetched after reset.
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; already registered from resetn at the top.
- ds_allowin  in  1  ID can accept an instruction this cycle.
- br_bus  in  33  {br_taken[32], br_target[31:0]} from ID; br_taken is already qualified by ID's valid.
- fs_to_ds_valid  out  1  fs_to_ds_bus holds a live instruction.
- fs_to_ds_bus  out  64  {fs_inst[63:32], fs_pc[31:0]}.
- inst_sram_en  out  1  read enable.
- inst_sram_we  out  4  constant 4'b0.
- inst_sram_addr  out  32  fetch address (nextpc).
- inst_sram_wdata  out  32  constant 32'b0.
- inst_sram_rdata  in  32  data for the address presented in the previous enabled cycle.

## Operation
- State: fs_valid, fs_pc[31:0], fs_cancel, br_pend, br_pend_target[31:0], ibuf_valid, ibuf[31:0].
- Pre-IF: to_fs_valid = ~reset; seq_pc = fs_pc + 32'd4 (mod 2^32, wrap allowed, no trap).
- nextpc = br_taken ? br_target : br_pend ? br_pend_target : seq_pc.
- drop = fs_cancel | br_taken. The held instruction is wrong-path and is never forwarded.
- fs_allowin = ~fs_valid | drop | ds_allowin. fs_ready_go is fixed at 1.
- inst_sram_en = to_fs_valid & fs_allowin; inst_sram_addr = nextpc.
- When fs_allowin is high: fs_valid <= to_fs_valid. If to_fs_valid is also high, fs_pc <= nextpc, fs_cancel <= 0, br_pend <= 0, ibuf_valid <= 0.
- When br_taken is high and fs_allowin is low: br_pend <= 1, br_pend_target <= br_target, and fs_cancel <= fs_valid. A later br_taken overwrites br_pend_target.
- Instruction buffer:
  - If fs_valid & ~fs_allowin & ~ibuf_valid: ibuf <= inst_sram_rdata, ibuf_valid <= 1.
  - fs_inst = ibuf_valid ? ibuf : inst_sram_rdata.
- fs_to_ds_valid = fs_valid & ~drop.
- fs_to_ds_bus = {fs_inst, fs_pc}.
- Reset values: fs_valid=0, fs_pc=RESET_PC-4, fs_cancel=0, br_pend=0, ibuf_valid=0, ibuf=0.
- Outputs during reset: fs_to_ds_valid=0, inst_sram_en=0, fs_to_ds_bus={0 or rdata, RESET_PC-4}.
- Reset mid-operation: all state returns to the reset values on the next edge. Pending redirects and buffered instructions are discarded.
- Misaligned br_target (bits [1:0]≠0) is passed through unchanged. ID is responsible for exceptions.

## Timing
- Fetch latency: address presented in cycle N → fs_to_ds_valid with that pc and inst in cycle N+1, provided no squash occurs.
- First cycle after reset deasserts (C0): inst_sram_en=1, addr=RESET_PC.
- C1: fs_to_ds_valid=1, fs_pc=RESET_PC.
- Throughput: one instruction per cycle while ds_allowin=1 and br_taken=0.
- Stall: while ds_allowin=0 and no branch, fs_pc, fs_to_ds_bus and fs_to_ds_valid are held constant and inst_sram_en=0.
- Buffer capture: ibuf captures rdata in the first stall cycle. Output stays correct even if SRAM rdata changes afterwards.
- Branch taken with fs_allowin=1: the redirect is fetched in the same cycle (addr=br_target). The held instruction is squashed that cycle. br_target reaches ID one cycle later.
- Branch taken while a stall blocks the redirect: cannot happen with drop in allowin, because fs_allowin is forced high. br_pend therefore only arises when reset=0 but the fetch is otherwise suppressed. It is kept for robustness, and the redirect must still be taken on the next enabled fetch.
- Simultaneous br_taken and ds_allowin=0: the held instruction is dropped and the redirect is fetched. Nothing is forwarded that cycle.
- Back-to-back br_taken on consecutive cycles: the second target wins. The instruction fetched from the first target is squashed.

## Test plan
- Reset release: hold reset 3 cycles, then release → C0 addr=0x1c000000, en=1. C1 valid=1, pc=0x1c000000. C2 pc=0x1c000004.
- Stall and buffer: in the cycle pc=0x1c000008 is valid, drive ds_allowin=0 for 4 cycles and change rdata to garbage after the first → bus holds {orig inst, 0x1c000008} and en=0. On resume, the next pc is 0x1c00000c.
- Taken branch: at pc=0x1c000010, br_bus={1, 0x1c000100} for 1 cycle → that cycle addr=0x1c000100 and fs_to_ds_valid=0. The next cycle pc=0x1c000100 and is valid. pc 0x1c000014 is never forwarded.
- Branch during ID stall: ds_allowin=0 with br_taken=1, target 0x1c000200 → the held instruction is dropped and the next valid pc is 0x1c000200.
- Back-to-back branches: targets 0x1c000300 then 0x1c000400 on consecutive cycles → pc 0x1c000300 is never forwarded valid. The next valid pc is 0x1c000400.
- Wrap and reset mid-stream:
  - Redirect to 0xfffffffc, then run → next pc is 0x00000000.
  - Assert reset during a stall → the next cycle has valid=0 and en=0. After release, fetch restarts at 0x1c000000.

Source files
------------

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: the valid/allowin handshake and branch bus towards ID,
// plus the instruction SRAM port. The fetch stage uses the master view.
interface if_stage_if;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  modport master (
    input  ds_allowin, br_bus, inst_sram_rdata,
    output fs_to_ds_valid, fs_to_ds_bus,
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );

  modport slave (
    output ds_allowin, br_bus, inst_sram_rdata,
    input  fs_to_ds_valid, fs_to_ds_bus,
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, reads a 1-cycle-latency SRAM, squashes
// wrong-path fetches on redirect and buffers the instruction while ID stalls.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        reset,
  if_stage_if.master  fs_bus
);

  logic        br_taken;
  logic [31:0] br_target;
  assign {br_taken, br_target} = fs_bus.br_bus;

  logic        fs_valid_q,       fs_valid_d;
  logic [31:0] fs_pc_q,          fs_pc_d;
  logic        fs_cancel_q,      fs_cancel_d;
  logic        br_pend_q,        br_pend_d;
  logic [31:0] br_pend_target_q, br_pend_target_d;
  logic        ibuf_valid_q,     ibuf_valid_d;
  logic [31:0] ibuf_q,           ibuf_d;

  logic        to_fs_valid;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic        drop;
  logic        fs_allowin;
  logic [31:0] fs_inst;

  assign to_fs_valid = ~reset;
  assign seq_pc      = fs_pc_q + 32'd4;
  assign nextpc      = br_taken  ? br_target :
                       br_pend_q ? br_pend_target_q : seq_pc;
  // A redirect makes the held instruction dead, so it never blocks the fetch.
  assign drop        = fs_cancel_q | br_taken;
  assign fs_allowin  = ~fs_valid_q | drop | fs_bus.ds_allowin;
  assign fs_inst     = ibuf_valid_q ? ibuf_q : fs_bus.inst_sram_rdata;

  always_comb begin
    // NOTE: every next-state signal starts from its current value so no path
    // through this block leaves one unassigned and infers a latch.
    fs_valid_d       = fs_valid_q;
    fs_pc_d          = fs_pc_q;
    fs_cancel_d      = fs_cancel_q;
    br_pend_d        = br_pend_q;
    br_pend_target_d = br_pend_target_q;
    ibuf_valid_d     = ibuf_valid_q;
    ibuf_d           = ibuf_q;

    if (fs_allowin) begin
      fs_valid_d = to_fs_valid;
      if (to_fs_valid) begin
        fs_pc_d      = nextpc;
        fs_cancel_d  = 1'b0;
        br_pend_d    = 1'b0;
        ibuf_valid_d = 1'b0;
      end
    end else if (br_taken) begin
      // Unreachable while drop feeds allowin; kept so a blocked redirect is not lost.
      br_pend_d        = 1'b1;
      br_pend_target_d = br_target;
      fs_cancel_d      = fs_valid_q;
    end

    // SRAM output is only guaranteed for one cycle; latch it on the first stall cycle.
    if (fs_valid_q && !fs_allowin && !ibuf_valid_q) begin
      ibuf_d       = fs_bus.inst_sram_rdata;
      ibuf_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      fs_valid_q       <= 1'b0;
      fs_pc_q          <= RESET_PC - 32'd4;
      fs_cancel_q      <= 1'b0;
      br_pend_q        <= 1'b0;
      br_pend_target_q <= 32'd0;
      ibuf_valid_q     <= 1'b0;
      ibuf_q           <= 32'd0;
    end else begin
      fs_valid_q       <= fs_valid_d;
      fs_pc_q          <= fs_pc_d;
      fs_cancel_q      <= fs_cancel_d;
      br_pend_q        <= br_pend_d;
      br_pend_target_q <= br_pend_target_d;
      ibuf_valid_q     <= ibuf_valid_d;
      ibuf_q           <= ibuf_d;
    end
  end

  assign fs_bus.fs_to_ds_valid  = fs_valid_q & ~drop;
  assign fs_bus.fs_to_ds_bus    = {fs_inst, fs_pc_q};
  assign fs_bus.inst_sram_en    = to_fs_valid & fs_allowin;
  assign fs_bus.inst_sram_addr  = nextpc;
  assign fs_bus.inst_sram_we    = 4'b0;
  assign fs_bus.inst_sram_wdata = 32'b0;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a per-cycle vector table covering reset, stall,
// redirects, wrap and mid-stream reset, plus a hand-written stall/branch sequence.
module tb_if_stage;

  localparam logic [31:0] R = 32'h1c00_0000;

  typedef struct {
    logic        rst;
    logic        da;
    logic        bt;
    logic [31:0] target;
    logic        garb;
    logic        chk;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_en;
    logic [31:0] exp_addr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        garbage;
  logic [31:0] sram_q;
  int          n_checks = 0;
  int          n_errors = 0;

  if_stage_if ifc ();

  if_stage #(.RESET_PC(R)) dut (
    .clk    (clk),
    .reset  (reset),
    .fs_bus (ifc.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // SRAM model: registered read, output forced to junk on demand.
  always @(posedge clk)
    if (ifc.inst_sram_en) sram_q <= inst_of(ifc.inst_sram_addr);
  assign ifc.inst_sram_rdata = garbage ? 32'hBAD0_BAD0 : sram_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic da, input logic bt,
                              input logic [31:0] target, input logic garb, input logic chk,
                              input logic ev, input logic [31:0] epc,
                              input logic een, input logic [31:0] eaddr);
    vec_t v;
    v.rst = rst; v.da = da; v.bt = bt; v.target = target; v.garb = garb; v.chk = chk;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_en = een; v.exp_addr = eaddr;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    reset          = v.rst;
    ifc.ds_allowin = v.da;
    ifc.br_bus     = {v.bt, v.target};
    garbage        = v.garb;
    #1;
    if (v.chk) begin
      check($sformatf("%s.valid", tag), {31'b0, ifc.fs_to_ds_valid}, {31'b0, v.exp_valid});
      check($sformatf("%s.pc", tag),    ifc.fs_to_ds_bus[31:0],      v.exp_pc);
      check($sformatf("%s.en", tag),    {31'b0, ifc.inst_sram_en},   {31'b0, v.exp_en});
      check($sformatf("%s.addr", tag),  ifc.inst_sram_addr,          v.exp_addr);
      if (v.exp_valid)
        check($sformatf("%s.inst", tag), ifc.fs_to_ds_bus[63:32], inst_of(v.exp_pc));
    end
  endtask

  vec_t vecs[$];

  initial begin
    reset          = 1'b1;
    garbage        = 1'b0;
    ifc.ds_allowin = 1'b1;
    ifc.br_bus     = 33'b0;

    // rst da bt target        garb chk  valid pc              en addr
    vecs.push_back(mk(1,1,0,0,            0,0, 0,0,              0,0));
    vecs.push_back(mk(1,1,0,0,            0,1, 0,R-4,            0,R));
    vecs.push_back(mk(1,1,0,0,            0,1, 0,R-4,            0,R));
    vecs.push_back(mk(0,1,0,0,            0,1, 0,R-4,            1,R));
    vecs.push_back(mk(0,1,0,0,            0,1, 1,R,              1,R+32'h4));
    vecs.push_back(mk(0,1,0,0,            0,1, 1,R+32'h4,        1,R+32'h8));
    vecs.push_back(mk(0,0,0,0,            0,1, 1,R+32'h8,        0,R+32'hc));
    vecs.push_back(mk(0,0,0,0,            1,1, 1,R+32'h8,        0,R+32'hc));
    vecs.push_back(mk(0,0,0,0,            1,1, 1,R+32'h8,        0,R+32'hc));
    vecs.push_back(mk(0,0,0,0,            1,1, 1,R+32'h8,        0,R+32'hc));
    vecs.push_back(mk(0,1,0,0,            0,1, 1,R+32'h8,        1,R+32'hc));
    vecs.push_back(mk(0,1,0,0,            0,1, 1,R+32'hc,        1,R+32'h10));
    vecs.push_back(mk(0,1,1,R+32'h100,    0,1, 0,R+32'h10,       1,R+32'h100));
    vecs.push_back(mk(0,1,0,0,            0,1, 1,R+32'h100,      1,R+32'h104));
    vecs.push_back(mk(0,0,1,R+32'h200,    0,1, 0,R+32'h104,      1,R+32'h200));
    vecs.push_back(mk(0,1,0,0,            0,1, 1,R+32'h200,      1,R+32'h204));
    vecs.push_back(mk(0,1,1,R+32'h300,    0,1, 0,R+32'h204,      1,R+32'h300));
    vecs.push_back(mk(0,1,1,R+32'h400,    0,1, 0,R+32'h300,      1,R+32'h400));
    vecs.push_back(mk(0,1,0,0,            0,1, 1,R+32'h400,      1,R+32'h404));
    vecs.push_back(mk(0,1,1,32'hffff_fffc,0,1, 0,R+32'h404,      1,32'hffff_fffc));
    vecs.push_back(mk(0,1,0,0,            0,1, 1,32'hffff_fffc, 1,32'h0));
    vecs.push_back(mk(0,1,0,0,            0,1, 1,32'h0,          1,32'h4));
    vecs.push_back(mk(0,0,0,0,            0,1, 1,32'h4,          0,32'h8));
    vecs.push_back(mk(1,0,0,0,            0,1, 1,32'h4,          0,32'h8));
    vecs.push_back(mk(1,0,0,0,            0,1, 0,R-4,            0,R));
    vecs.push_back(mk(0,1,0,0,            0,1, 0,R-4,            1,R));
    vecs.push_back(mk(0,1,0,0,            0,1, 1,R,              1,R+32'h4));

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Branch arriving while the buffer holds a stalled instruction: the buffer
    // must be discarded and the redirect target forwarded from fresh SRAM data.
    apply(mk(0,0,0,0,          0,1, 1,R+32'h4,  0,R+32'h8),   "s_stall");
    apply(mk(0,0,0,0,          1,1, 1,R+32'h4,  0,R+32'h8),   "s_buf");
    apply(mk(0,0,1,R+32'h80,   1,1, 0,R+32'h4,  1,R+32'h80),  "s_br");
    apply(mk(0,1,0,0,          0,1, 1,R+32'h80, 1,R+32'h84),  "s_tgt");
    apply(mk(0,1,0,0,          0,1, 1,R+32'h84, 1,R+32'h88),  "s_seq");
    // Misaligned redirect target passes through untouched.
    apply(mk(0,1,1,R+32'h102,  0,1, 0,R+32'h88, 1,R+32'h102), "s_mis");
    apply(mk(0,1,0,0,          0,1, 1,R+32'h102,1,R+32'h106), "s_mis_pc");

    check("sram_we",    {28'b0, ifc.inst_sram_we}, 32'h0);
    check("sram_wdata", ifc.inst_sram_wdata,       32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
